// File: rtl/sigchk_pkg.sv
// Shared definitions for the sigchk sequence checker: FSM state encoding,
// symbol width and the default lock/unlock run lengths.
package sigchk_pkg;

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int SYM_W          = 8;
  localparam int LOCK_CNT_DEF   = 4;
  localparam int UNLOCK_CNT_DEF = 8;

endpackage

// File: rtl/sigchk_popcnt8.sv
// Combinational population count of an 8-bit word (0..8), used to weigh
// symbol errors by the number of flipped bits.
module popcnt8 (
  input  logic [7:0] din,
  output logic [3:0] cnt
);

  // Add up the set bits of the input word
  always_comb begin
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'd0, din[i]};
    end
  end

endmodule

// File: rtl/sigchk.sv
// Incrementing-sequence checker: hunts for LOCK_CNT in-order symbols, then
// counts symbol and bit errors while locked, dropping lock after UNLOCK_CNT
// consecutive mismatches.
module sigchk
  import sigchk_pkg::*;
#(
  parameter int LOCK_CNT   = LOCK_CNT_DEF,
  parameter int UNLOCK_CNT = UNLOCK_CNT_DEF,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SYM_W-1:0] data,
  input  logic             clr,
  output logic             locked,
  output logic [CNT_W-1:0] sym_cnt,
  output logic [CNT_W-1:0] sym_err_cnt,
  output logic [CNT_W-1:0] bit_err_cnt,
  output logic             err_pulse
);

  localparam logic [0:0] ST_HUNT    = HUNT;
  localparam logic [0:0] ST_LOCKED  = LOCKED;
  localparam logic [8:0] LOCK_CMP   = 9'(LOCK_CNT);
  localparam logic [8:0] UNLOCK_CMP = 9'(UNLOCK_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [0:0]       state_r;
  logic [0:0]       state_nxt_s;
  logic [7:0]       exp_r;
  logic [7:0]       exp_nxt_s;
  logic [7:0]       run_r;
  logic [7:0]       run_nxt_s;
  logic [8:0]       run_inc_s;
  logic             match_s;
  logic             sym_inc_s;
  logic             err_s;
  logic [3:0]       pop_s;
  logic [CNT_W:0]   bit_sum_s;
  logic [CNT_W-1:0] sym_cnt_nxt_s;
  logic [CNT_W-1:0] sym_err_nxt_s;
  logic [CNT_W-1:0] bit_err_nxt_s;

  popcnt8 u_popcnt8 (
    .din (data ^ exp_r),
    .cnt (pop_s)
  );

  // Sample classification and next FSM / expected / run values
  always_comb begin
    match_s     = (data == exp_r);
    run_inc_s   = {1'b0, run_r} + 9'd1;
    state_nxt_s = state_r;
    exp_nxt_s   = exp_r;
    run_nxt_s   = run_r;
    sym_inc_s   = 1'b0;
    err_s       = 1'b0;
    if (en) begin
      case (state_r)
        ST_HUNT: begin
          // Hunting reseeds from the received symbol every sample
          exp_nxt_s = data + 8'd1;
          if (match_s) begin
            if (run_inc_s == LOCK_CMP) begin
              state_nxt_s = ST_LOCKED;
              run_nxt_s   = 8'd0;
            end else begin
              run_nxt_s = run_inc_s[7:0];
            end
          end else begin
            run_nxt_s = 8'd0;
          end
        end
        ST_LOCKED: begin
          sym_inc_s = 1'b1;
          if (match_s) begin
            exp_nxt_s = exp_r + 8'd1;
            run_nxt_s = 8'd0;
          end else begin
            err_s = 1'b1;
            if (run_inc_s == UNLOCK_CMP) begin
              state_nxt_s = ST_HUNT;
              run_nxt_s   = 8'd0;
              exp_nxt_s   = data + 8'd1;
            end else begin
              run_nxt_s = run_inc_s[7:0];
              exp_nxt_s = exp_r + 8'd1;
            end
          end
        end
        default: begin
          state_nxt_s = ST_HUNT;
          run_nxt_s   = 8'd0;
          exp_nxt_s   = 8'd0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Saturating next values for the statistics counters
  always_comb begin
    bit_sum_s = {1'b0, bit_err_cnt} + (CNT_W+1)'(pop_s);
    if (sym_cnt == CNT_MAX) begin
      sym_cnt_nxt_s = CNT_MAX;
    end else begin
      sym_cnt_nxt_s = sym_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    if (sym_err_cnt == CNT_MAX) begin
      sym_err_nxt_s = CNT_MAX;
    end else begin
      sym_err_nxt_s = sym_err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    // A multi-bit add can jump past all-ones, so clamp on the carry
    if (bit_sum_s[CNT_W]) begin
      bit_err_nxt_s = CNT_MAX;
    end else begin
      bit_err_nxt_s = bit_sum_s[CNT_W-1:0];
    end
  end

  // State, expected symbol, run length, outputs and statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_HUNT;
      exp_r       <= 8'd0;
      run_r       <= 8'd0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      sym_cnt     <= {CNT_W{1'b0}};
      sym_err_cnt <= {CNT_W{1'b0}};
      bit_err_cnt <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      exp_r     <= exp_nxt_s;
      run_r     <= run_nxt_s;
      locked    <= (state_nxt_s == ST_LOCKED);
      err_pulse <= err_s;
      if (clr) begin
        sym_cnt     <= {CNT_W{1'b0}};
        sym_err_cnt <= {CNT_W{1'b0}};
        bit_err_cnt <= {CNT_W{1'b0}};
      end else begin
        if (sym_inc_s) begin
          sym_cnt <= sym_cnt_nxt_s;
        end
        if (err_s) begin
          sym_err_cnt <= sym_err_nxt_s;
          bit_err_cnt <= bit_err_nxt_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_sigchk.sv
// Directed bench for sigchk: default instance plus a 4-bit-counter instance
// with a long unlock run to exercise saturation.
module tb_sigchk;
  import sigchk_pkg::*;

  logic        clk;
  logic        rst;
  logic        en;
  logic [7:0]  data;
  logic        clr;

  logic        locked;
  logic [31:0] sym_cnt;
  logic [31:0] sym_err_cnt;
  logic [31:0] bit_err_cnt;
  logic        err_pulse;

  logic        sat_locked;
  logic [3:0]  sat_sym_cnt;
  logic [3:0]  sat_sym_err_cnt;
  logic [3:0]  sat_bit_err_cnt;
  logic        sat_err_pulse;

  int checks;
  int errors;
  logic seen;

  sigchk u_dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .data        (data),
    .clr         (clr),
    .locked      (locked),
    .sym_cnt     (sym_cnt),
    .sym_err_cnt (sym_err_cnt),
    .bit_err_cnt (bit_err_cnt),
    .err_pulse   (err_pulse)
  );

  sigchk #(.CNT_W(4), .UNLOCK_CNT(32)) u_sat (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .data        (data),
    .clr         (clr),
    .locked      (sat_locked),
    .sym_cnt     (sat_sym_cnt),
    .sym_err_cnt (sat_sym_err_cnt),
    .bit_err_cnt (sat_bit_err_cnt),
    .err_pulse   (sat_err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Drive one sample on the falling edge; return #1 after the next rising edge
  task automatic cycle(input logic r, input logic e, input logic [7:0] d, input logic c);
    @(negedge clk);
    rst  = r;
    en   = e;
    data = d;
    clr  = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; en = 1'b0; data = 8'h00; clr = 1'b0;

    // Reset overrides en and clr
    cycle(1'b1, 1'b1, 8'h5A, 1'b1);
    cycle(1'b1, 1'b1, 8'h01, 1'b0);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_pulse", {31'd0, err_pulse}, 32'd0);
    check("rst_sym", sym_cnt, 32'd0);
    check("rst_bit", bit_err_cnt, 32'd0);

    // Lock on 0x10..0x14 (0x10 only seeds)
    for (int i = 8'h10; i <= 8'h13; i++) cycle(1'b0, 1'b1, 8'(i), 1'b0);
    check("lock_early", {31'd0, locked}, 32'd0);
    cycle(1'b0, 1'b1, 8'h14, 1'b0);
    check("lock_rise", {31'd0, locked}, 32'd1);
    check("lock_sym", sym_cnt, 32'd0);
    check("lock_serr", sym_err_cnt, 32'd0);
    check("lock_bit", bit_err_cnt, 32'd0);

    // en low: garbage ignored
    cycle(1'b0, 1'b0, 8'h77, 1'b0);
    check("idle_sym", sym_cnt, 32'd0);
    check("idle_pulse", {31'd0, err_pulse}, 32'd0);

    // Clean run through the 0xFF->0x00 wrap
    seen = 1'b0;
    for (int i = 8'h15; i <= 8'hFF; i++) begin
      cycle(1'b0, 1'b1, 8'(i), 1'b0);
      seen = seen | err_pulse;
    end
    for (int i = 0; i <= 4; i++) begin
      cycle(1'b0, 1'b1, 8'(i), 1'b0);
      seen = seen | err_pulse;
    end
    check("clean_sym", sym_cnt, 32'd240);
    check("clean_serr", sym_err_cnt, 32'd0);
    check("clean_pulse", {31'd0, seen}, 32'd0);

    // Advance to exp=0x20, then 0x2F (4 bits off)
    for (int i = 5; i <= 8'h1F; i++) cycle(1'b0, 1'b1, 8'(i), 1'b0);
    cycle(1'b0, 1'b1, 8'h2F, 1'b0);
    check("berr_pulse", {31'd0, err_pulse}, 32'd1);
    check("berr_serr", sym_err_cnt, 32'd1);
    check("berr_bit", bit_err_cnt, 32'd4);
    check("berr_sym", sym_cnt, 32'd268);
    cycle(1'b0, 1'b1, 8'h21, 1'b0);
    check("berr_next_pulse", {31'd0, err_pulse}, 32'd0);
    check("berr_next_serr", sym_err_cnt, 32'd1);
    check("berr_next_lock", {31'd0, locked}, 32'd1);

    // Advance to exp=0x40, then 8 zeros against 0x40..0x47
    for (int i = 8'h22; i <= 8'h3F; i++) cycle(1'b0, 1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
    check("unl_7_lock", {31'd0, locked}, 32'd1);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    check("unl_8_lock", {31'd0, locked}, 32'd0);
    check("unl_8_pulse", {31'd0, err_pulse}, 32'd1);
    check("unl_serr", sym_err_cnt, 32'd9);
    check("unl_bit", bit_err_cnt, 32'd24);
    check("unl_sym", sym_cnt, 32'd307);

    // Relock: exp reseeded to 0x01, needs 4 matches
    for (int i = 1; i <= 3; i++) cycle(1'b0, 1'b1, 8'(i), 1'b0);
    check("relock_early", {31'd0, locked}, 32'd0);
    cycle(1'b0, 1'b1, 8'h04, 1'b0);
    check("relock", {31'd0, locked}, 32'd1);
    check("relock_sym", sym_cnt, 32'd307);

    // clr with a mismatching sample (exp=0x05)
    cycle(1'b0, 1'b1, 8'h00, 1'b1);
    check("clr_sym", sym_cnt, 32'd0);
    check("clr_serr", sym_err_cnt, 32'd0);
    check("clr_bit", bit_err_cnt, 32'd0);
    check("clr_pulse", {31'd0, err_pulse}, 32'd1);
    check("clr_lock", {31'd0, locked}, 32'd1);
    cycle(1'b0, 1'b1, 8'h06, 1'b0);
    check("clr_after_sym", sym_cnt, 32'd1);
    check("clr_after_pulse", {31'd0, err_pulse}, 32'd0);

    // Saturation: restart, lock, 20 all-bits-wrong samples
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 8'h10; i <= 8'h14; i++) cycle(1'b0, 1'b1, 8'(i), 1'b0);
    check("sat_lock", {31'd0, sat_locked}, 32'd1);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 8'(8'h15 + i) ^ 8'hFF, 1'b0);
    check("sat_sym", {28'd0, sat_sym_cnt}, 32'd15);
    check("sat_serr", {28'd0, sat_sym_err_cnt}, 32'd15);
    check("sat_bit", {28'd0, sat_bit_err_cnt}, 32'd15);
    check("sat_still_locked", {31'd0, sat_locked}, 32'd1);
    check("dflt_unlock_sym", sym_cnt, 32'd8);
    check("dflt_unlock_bit", bit_err_cnt, 32'd64);
    check("dflt_unlock_lock", {31'd0, locked}, 32'd0);

    // Mid-operation reset drops the in-flight sample; exp restarts at 0x00
    cycle(1'b1, 1'b1, 8'hAA, 1'b0);
    check("midrst_lock", {31'd0, sat_locked}, 32'd0);
    check("midrst_sym", {28'd0, sat_sym_cnt}, 32'd0);
    check("midrst_pulse", {31'd0, sat_err_pulse}, 32'd0);
    for (int i = 0; i <= 2; i++) cycle(1'b0, 1'b1, 8'(i), 1'b0);
    check("midrst_hunt", {31'd0, sat_locked}, 32'd0);
    cycle(1'b0, 1'b1, 8'h03, 1'b0);
    check("midrst_relock", {31'd0, sat_locked}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sigchk.md
SIGCHK -- requirements
Module: sigchk

Interface
REQ-001 Parameter LOCK_CNT, default 4: consecutive in-sequence samples required to enter LOCKED; legal range 1..255.
REQ-002 Parameter UNLOCK_CNT, default 8: consecutive mismatching samples that drop LOCKED back to HUNT; legal range 1..255.
REQ-003 Parameter CNT_W, default 32: width of every statistics counter.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 en  input  1  sample valid; data is consumed only on cycles with en high.
REQ-007 data  input  8  received symbol from the sigin-style incrementing source, after the channel under test.
REQ-008 clr  input  1  synchronous clear of the statistics counters.
REQ-009 locked  output  1  high while the checker is in LOCKED.
REQ-010 sym_cnt  output  CNT_W  symbols checked while LOCKED.
REQ-011 sym_err_cnt  output  CNT_W  symbols that mismatched while LOCKED.
REQ-012 bit_err_cnt  output  CNT_W  total bits in error, popcount(data XOR expected), while LOCKED.
REQ-013 err_pulse  output  1  one-cycle strobe per mismatching LOCKED sample.

Function
REQ-014 The checker SHALL hold an 8-bit expected register exp and a two-state FSM: HUNT and LOCKED.
REQ-015 Cycles with en low SHALL change no state, exp, run counter or statistic; err_pulse SHALL be low on the following cycle.
REQ-016 HUNT, en high: if data==exp, run increments, else run clears to 0; exp SHALL load data+1 (mod 256) regardless.
REQ-017 HUNT: the matching sample that makes run equal LOCK_CNT SHALL move the FSM to LOCKED and clear run; locked is high on the next cycle; that sample is not counted.
REQ-018 LOCKED, en high: exp SHALL increment by 1, wrapping 0xFF->0x00, independent of data (no reseed).
REQ-019 LOCKED, en high: sym_cnt +1; on mismatch, sym_err_cnt +1, bit_err_cnt + popcount(data^exp) (0..8), err_pulse high next cycle, run +1; on match, run clears.
REQ-020 LOCKED: the mismatching sample that makes run equal UNLOCK_CNT SHALL be counted, then FSM goes to HUNT, run clears, exp loads data+1.
REQ-021 All outputs SHALL be registered; the effect of a sample appears exactly one cycle after the en-high edge.
REQ-022 Every counter SHALL saturate at all-ones and never wrap; bit_err_cnt saturates rather than overflowing on a multi-bit add.
REQ-023 clr SHALL zero all three counters on the next edge, take priority over a simultaneous increment (that sample is dropped from statistics), and SHALL NOT affect FSM, exp, run or err_pulse.

Reset
REQ-024 rst high SHALL set FSM=HUNT, exp=0x00, run=0, locked=0, err_pulse=0 and all counters=0 on the next edge, overriding en and clr.
REQ-025 rst asserted mid-operation SHALL discard the in-flight sample; checking restarts from HUNT.

Structure
REQ-026 Shared package sigchk_pkg SHALL hold the FSM state enum (HUNT, LOCKED), the symbol width constant (8) and the default LOCK_CNT/UNLOCK_CNT values.
REQ-027 Bit counting SHALL be a sub-module popcnt8 (8-bit in, 4-bit count out, combinational).

Verification
REQ-028 Lock: after reset, en high with data 0x10,0x11,0x12,0x13,0x14 -> locked rises the cycle after 0x14; all counters 0.
REQ-029 Clean run with wrap: locked, then data 0x15..0xFF,0x00..0x04 -> sym_cnt=240, sym_err_cnt=0, err_pulse never high.
REQ-030 Bit error: locked with exp=0x20, data 0x2F -> sym_err_cnt +1, bit_err_cnt +4, single err_pulse, next sample 0x21 -> no error.
REQ-031 Unlock: locked, 8 consecutive samples of 0x00 against exp 0x40..0x47 -> sym_err_cnt=8, locked falls the cycle after the 8th, relock needs 4 further matches.
REQ-032 clr concurrent with a mismatching sample -> all counters 0 next cycle, err_pulse still high, locked unchanged.
REQ-033 Saturation: CNT_W=4, locked, 20 samples each with 0xFF^exp -> sym_err_cnt=15, bit_err_cnt=15, sym_cnt=15.
